// File: rtl/dprc_pkg.sv
// Shared types for the range counter: control states and step substitution.
// The optional running-sum output is enabled by defining DPRC_SUM_EN.
package dprc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    EMIT  = 3'd3,
    INC   = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic {
    A_SRC_ZERO = 1'b0,
    A_SRC_SUM  = 1'b1
  } a_src_e;

  // A requested step of 0 would never advance, so it runs as this value instead.
  localparam int STEP_ZERO_SUB = 1;

  function automatic logic [31:0] step_fix(input logic [31:0] step_in);
    return (step_in == '0) ? 32'(STEP_ZERO_SUB) : step_in;
  endfunction

endpackage

// File: rtl/dprc_datapath.sv
// Range counter datapath: A register, carry-out adder, limit comparator, out register.
// With DPRC_SUM_EN it also carries the 2*WIDTH running-sum accumulator.
module dprc_datapath
  import dprc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [WIDTH-1:0]   limit,
  input  logic [WIDTH-1:0]   step,
  input  a_src_e             a_src_sel,
  input  logic               a_load,
  input  logic               out_load,
`ifdef DPRC_SUM_EN
  input  logic               acc_clr,
  input  logic               acc_add,
  output logic [2*WIDTH-1:0] sum,
`endif
  output logic               a_lt_limit,
  output logic               inc_carry,
  output logic [WIDTH-1:0]   out
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] limit_r;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_fixed;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] out_reg;

  assign step_fixed = (step == '0) ? WIDTH'(STEP_ZERO_SUB) : step;

  // One extra bit so an overflowing increment is seen instead of wrapping A.
  assign inc_sum    = {1'b0, a_reg} + {1'b0, step_r};
  assign inc_carry  = inc_sum[WIDTH];
  assign a_lt_limit = (a_reg < limit_r);

  always_comb begin
    a_next = '0;
    case (a_src_sel)
      A_SRC_SUM:  a_next = inc_sum[WIDTH-1:0];
      default:    a_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit_r <= '0;
      step_r  <= WIDTH'(STEP_ZERO_SUB);
    end else if (cfg_load) begin
      limit_r <= limit;
      step_r  <= step_fixed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
    end else if (a_load) begin
      a_reg <= a_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg <= '0;
    end else if (out_load) begin
      out_reg <= a_reg;
    end
  end

  assign out = out_reg;

`ifdef DPRC_SUM_EN
  logic [2*WIDTH-1:0] acc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (acc_clr) begin
      acc_reg <= '0;
    end else if (acc_add) begin
      acc_reg <= acc_reg + {{WIDTH{1'b0}}, out_reg};
    end
  end

  assign sum = acc_reg;
`endif

endmodule

// File: rtl/dedicated_processor_range_counter.sv
// Range counter top: Moore control FSM with registered outputs driving dprc_datapath.
// Define DPRC_SUM_EN to add the running-sum output port.
module dedicated_processor_range_counter
  import dprc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   limit,
  input  logic [WIDTH-1:0]   step,
  output logic               busy,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out,
`ifdef DPRC_SUM_EN
  output logic [2*WIDTH-1:0] sum,
`endif
  output logic               done
);

  state_e state;
  logic   busy_reg;
  logic   out_valid_reg;
  logic   done_reg;

  logic   cfg_load;
  a_src_e a_src_sel;
  logic   a_load;
  logic   out_load;
  logic   a_lt_limit;
  logic   inc_carry;
`ifdef DPRC_SUM_EN
  logic   acc_clr;
  logic   acc_add;
`endif

  // Datapath strobes decode the current state so they act on the same edge the FSM moves.
  always_comb begin
    cfg_load  = 1'b0;
    a_src_sel = A_SRC_ZERO;
    a_load    = 1'b0;
    out_load  = 1'b0;
    case (state)
      IDLE:  cfg_load = start;
      INIT:  a_load   = 1'b1;
      CHECK: out_load = a_lt_limit;
      INC: begin
        a_src_sel = A_SRC_SUM;
        a_load    = ~inc_carry;
      end
      default: ;
    endcase
  end

`ifdef DPRC_SUM_EN
  assign acc_clr = (state == INIT);
  assign acc_add = (state == EMIT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      busy_reg      <= 1'b1;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= INIT;
          end else begin
            busy_reg <= 1'b0;
          end
        end
        INIT: state <= CHECK;
        CHECK: begin
          if (a_lt_limit) begin
            state         <= EMIT;
            out_valid_reg <= 1'b1;
          end else begin
            state    <= DONE;
            done_reg <= 1'b1;
          end
        end
        EMIT: state <= INC;
        INC: begin
          if (inc_carry) begin
            state    <= DONE;
            done_reg <= 1'b1;
          end else begin
            state <= CHECK;
          end
        end
        DONE: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign out_valid = out_valid_reg;
  assign done      = done_reg;

  dprc_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .limit      (limit),
    .step       (step),
    .a_src_sel  (a_src_sel),
    .a_load     (a_load),
    .out_load   (out_load),
`ifdef DPRC_SUM_EN
    .acc_clr    (acc_clr),
    .acc_add    (acc_add),
    .sum        (sum),
`endif
    .a_lt_limit (a_lt_limit),
    .inc_carry  (inc_carry),
    .out        (out)
  );

endmodule

// File: tb/tb_dedicated_processor_range_counter.sv
// Self-checking bench for the range counter against an arithmetic reference model.
// Define DPRC_SUM_EN to also check the running sum.
module tb_dedicated_processor_range_counter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] limit;
  logic [7:0] step;
  logic       busy;
  logic       out_valid;
  logic [7:0] out;
  logic       done;
`ifdef DPRC_SUM_EN
  logic [15:0] sum;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model results.
  int exp_vals[$];
  int exp_done;
  int exp_sum;

  // Observations from one run.
  int cap_vals[$];
  int cap_cycs[$];
  int cap_done;
  int cap_done_cnt;
  int cap_fall;
  int cap_sum;
  bit cap_timeout;
  logic cap_busy0;

  dedicated_processor_range_counter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .limit     (limit),
    .step      (step),
    .busy      (busy),
    .out_valid (out_valid),
    .out       (out),
`ifdef DPRC_SUM_EN
    .sum       (sum),
`endif
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Values are 0, s, 2s, ... below lim; one past 255 ends the run right after the INC.
  task automatic model(input int lim, input int stp);
    int s;
    int a;
    bit ovf;
    s = (stp == 0) ? 1 : stp;
    a = 0;
    ovf = 0;
    exp_vals.delete();
    exp_sum = 0;
    while (a < lim) begin
      exp_vals.push_back(a);
      exp_sum += a;
      if (a + s > 255) begin
        ovf = 1;
        break;
      end
      a += s;
    end
    exp_done = ovf ? 3 * exp_vals.size() + 1 : 3 * exp_vals.size() + 2;
  endtask

  // Launches one run (E0 = first rising edge after the call) and records what the DUT does.
  task automatic run_capture(input logic [7:0] lim, input logic [7:0] stp, input bit hold,
                             input bit scramble, input int chg_at, input logic [7:0] chg_lim);
    int cyc;
    cap_vals.delete();
    cap_cycs.delete();
    cap_done = -1;
    cap_done_cnt = 0;
    cap_fall = -1;
    cap_sum = -1;
    cap_timeout = 0;
    @(negedge clk);
    start = 1'b1;
    limit = lim;
    step  = stp;
    @(posedge clk);
    #1;
    cap_busy0 = busy;
    if (!hold) start = 1'b0;
    cyc = 0;
    while (1) begin
      if (scramble) begin
        limit = 8'($urandom);
        step  = 8'($urandom);
      end
      if (cyc == chg_at) limit = chg_lim;
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) begin
        cap_vals.push_back(int'(out));
        cap_cycs.push_back(cyc);
      end
      if (done) begin
        if (cap_done < 0) cap_done = cyc;
        cap_done_cnt++;
`ifdef DPRC_SUM_EN
        cap_sum = int'(sum);
`endif
      end
      if (!busy) begin
        cap_fall = cyc;
        break;
      end
      if (cyc >= 1000) begin
        cap_timeout = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    limit = 8'd0;
    step = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++;
    if (out !== 8'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
`ifdef DPRC_SUM_EN
    checks++;
    if (sum !== 16'd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", sum); end
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
    $display("reset: idle after release busy=%0b out=%0d", busy, out);
  endtask

  task automatic test_count_0_to_9();
    model(10, 1);
    run_capture(8'd10, 8'd1, 1'b0, 1'b0, -1, 8'd0);
    checks++;
    if (cap_timeout) begin errors++; $display("FAIL basic_timeout: got timeout expected busy fall"); end
    checks++;
    if (cap_busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %0b expected 1", cap_busy0); end
    checks++;
    if (cap_vals.size() != exp_vals.size()) begin
      errors++; $display("FAIL basic_count: got %0d expected %0d", cap_vals.size(), exp_vals.size());
    end else begin
      for (int k = 0; k < exp_vals.size(); k++) begin
        checks++;
        if (cap_vals[k] != exp_vals[k] || cap_cycs[k] != 3 * k + 2) begin
          errors++;
          $display("FAIL basic_emit%0d: got %0d@%0d expected %0d@%0d", k, cap_vals[k], cap_cycs[k], exp_vals[k], 3 * k + 2);
        end
      end
    end
    checks++;
    if (cap_done != exp_done || cap_done_cnt != 1) begin
      errors++; $display("FAIL basic_done: got cycle %0d x%0d expected cycle %0d x1", cap_done, cap_done_cnt, exp_done);
    end
    checks++;
    if (cap_fall != exp_done + 1) begin errors++; $display("FAIL basic_busy_fall: got %0d expected %0d", cap_fall, exp_done + 1); end
    checks++;
    if (out !== 8'd9) begin errors++; $display("FAIL basic_out_hold: got %0d expected 9", out); end
`ifdef DPRC_SUM_EN
    checks++;
    if (cap_sum != 45) begin errors++; $display("FAIL basic_sum: got %0d expected 45", cap_sum); end
`endif
    $display("count_0_to_9: emitted %0d values, done at cycle %0d", cap_vals.size(), cap_done);
  endtask

  task automatic test_limit_zero();
    run_capture(8'd0, 8'd1, 1'b0, 1'b0, -1, 8'd0);
    checks++;
    if (cap_vals.size() != 0) begin errors++; $display("FAIL zero_emits: got %0d expected 0", cap_vals.size()); end
    checks++;
    if (cap_done != 2 || cap_done_cnt != 1) begin
      errors++; $display("FAIL zero_done: got cycle %0d x%0d expected cycle 2 x1", cap_done, cap_done_cnt);
    end
    checks++;
    if (cap_fall != 3 || cap_busy0 !== 1'b1) begin
      errors++; $display("FAIL zero_busy: got fall %0d busy0 %0b expected fall 3 busy0 1", cap_fall, cap_busy0);
    end
    $display("limit_zero: done at cycle %0d, busy fell at %0d", cap_done, cap_fall);
  endtask

  task automatic test_overflow();
    model(255, 100);
    run_capture(8'd255, 8'd100, 1'b0, 1'b0, -1, 8'd0);
    checks++;
    if (cap_vals.size() != 3) begin
      errors++; $display("FAIL ovf_count: got %0d expected 3", cap_vals.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (cap_vals[k] != exp_vals[k]) begin
          errors++; $display("FAIL ovf_emit%0d: got %0d expected %0d", k, cap_vals[k], exp_vals[k]);
        end
      end
    end
    checks++;
    if (cap_done != 10 || cap_done != exp_done) begin
      errors++; $display("FAIL ovf_done: got cycle %0d expected 10", cap_done);
    end
`ifdef DPRC_SUM_EN
    checks++;
    if (cap_sum != 300) begin errors++; $display("FAIL ovf_sum: got %0d expected 300", cap_sum); end
`endif
    $display("overflow: emitted %0d values, done at cycle %0d", cap_vals.size(), cap_done);
  endtask

  task automatic test_step_zero();
    run_capture(8'd3, 8'd0, 1'b0, 1'b0, -1, 8'd0);
    checks++;
    if (cap_vals.size() != 3) begin
      errors++; $display("FAIL step0_count: got %0d expected 3", cap_vals.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (cap_vals[k] != k) begin errors++; $display("FAIL step0_emit%0d: got %0d expected %0d", k, cap_vals[k], k); end
      end
    end
    checks++;
    if (cap_done != 11) begin errors++; $display("FAIL step0_done: got cycle %0d expected 11", cap_done); end
    $display("step_zero: emitted %0d values", cap_vals.size());
  endtask

  task automatic test_held_start();
    // start stays high and limit drops to 2 mid-run; the run keeps limit 5.
    run_capture(8'd5, 8'd1, 1'b1, 1'b0, 3, 8'd2);
    checks++;
    if (cap_vals.size() != 5 || cap_done_cnt != 1) begin
      errors++; $display("FAIL held_run1: got %0d values %0d dones expected 5 values 1 done", cap_vals.size(), cap_done_cnt);
    end
    checks++;
    if (cap_fall != 18) begin errors++; $display("FAIL held_fall: got %0d expected 18", cap_fall); end
    // The edge right after busy falls samples the still-high start with limit 2 latched.
    run_capture(8'd2, 8'd1, 1'b0, 1'b0, -1, 8'd0);
    checks++;
    if (cap_busy0 !== 1'b1) begin errors++; $display("FAIL held_restart: got busy %0b expected 1", cap_busy0); end
    checks++;
    if (cap_vals.size() != 2 || cap_done != 8) begin
      errors++; $display("FAIL held_run2: got %0d values done %0d expected 2 values done 8", cap_vals.size(), cap_done);
    end
    $display("held_start: second run emitted %0d values", cap_vals.size());
  endtask

  task automatic test_reset_mid_run();
    int seen;
    int cyc;
    int done_seen;
    seen = 0;
    cyc = 0;
    done_seen = 0;
    @(negedge clk);
    start = 1'b1;
    limit = 8'd10;
    step = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (seen < 2 && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 2) begin errors++; $display("FAIL midrst_reach: got %0d emits expected 2", seen); end
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 8'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state: got out %0d busy %0b valid %0b expected 0 0 0", out, busy, out_valid);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL midrst_done: got %0d pulses expected 0", done_seen); end
    model(10, 1);
    run_capture(8'd10, 8'd1, 1'b0, 1'b0, -1, 8'd0);
    checks++;
    if (cap_vals != exp_vals || cap_done != exp_done) begin
      errors++; $display("FAIL midrst_rerun: got %0d values done %0d expected %0d values done %0d",
                         cap_vals.size(), cap_done, exp_vals.size(), exp_done);
    end
    $display("reset_mid_run: rerun emitted %0d values", cap_vals.size());
  endtask

  task automatic test_random();
    logic [7:0] lim;
    logic [7:0] stp;
    int bad;
    for (int r = 0; r < 8; r++) begin
      lim = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      model(int'(lim), int'(stp));
      run_capture(lim, stp, 1'b0, 1'b1, -1, 8'd0);
      bad = 0;
      if (cap_vals.size() != exp_vals.size()) bad = 1;
      else
        for (int k = 0; k < exp_vals.size(); k++)
          if (cap_vals[k] != exp_vals[k] || cap_cycs[k] != 3 * k + 2) bad = 1;
      checks++;
      if (bad != 0 || cap_timeout) begin
        errors++; $display("FAIL rand%0d_values: got %0d values expected %0d (limit %0d step %0d)",
                           r, cap_vals.size(), exp_vals.size(), lim, stp);
      end
      checks++;
      if (cap_done != exp_done || cap_done_cnt != 1 || cap_fall != exp_done + 1) begin
        errors++; $display("FAIL rand%0d_done: got %0d x%0d fall %0d expected %0d x1 fall %0d",
                           r, cap_done, cap_done_cnt, cap_fall, exp_done, exp_done + 1);
      end
`ifdef DPRC_SUM_EN
      checks++;
      if (cap_sum != exp_sum) begin errors++; $display("FAIL rand%0d_sum: got %0d expected %0d", r, cap_sum, exp_sum); end
`endif
      $display("random run %0d: limit %0d step %0d emitted %0d done %0d", r, lim, stp, cap_vals.size(), cap_done);
    end
  endtask

  initial begin
    test_reset();
    test_count_0_to_9();
    test_limit_zero();
    test_overflow();
    test_step_zero();
    test_held_start();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
